// File: rtl/regcsr_mp_pkg.sv
// csr_pkg: shared CSR constants and types for the regcsr_mp register file.
//   DEF_DATA_W / DEF_ADDR_W : default CSR width and index width
//   CSR_CYC                 : free-running cycle-counter CSR index
//   CSR_MATH_CTRL..CSR_OPC  : math-engine CSRs exported on the tap bus
//   aux_entry_t             : one buffered aux write {addr, data}
package csr_pkg;

  localparam int unsigned DEF_DATA_W = 24;
  localparam int unsigned DEF_ADDR_W = 8;

  localparam logic [7:0] CSR_CYC       = 8'h01;
  localparam logic [7:0] CSR_MATH_CTRL = 8'h10;
  localparam logic [7:0] CSR_OPA       = 8'h11;
  localparam logic [7:0] CSR_OPB       = 8'h12;
  localparam logic [7:0] CSR_OPC       = 8'h13;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } aux_entry_t;

endpackage

// File: rtl/regcsr_mp_if.sv
// regcsr_mp_if: CSR bus bundle (read ports, CPU write, aux write channel,
// status and tap outputs).
//   master : pipeline / aux requester side (drives indices, writes, aux req)
//   slave  : register-file side (drives read data, aux status, taps)
interface regcsr_mp_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] iw_read_addr;
  logic [NUM_RD*DATA_W-1:0] ow_read_data;
  logic                     iw_write_enable;
  logic [ADDR_W-1:0]        iw_write_addr;
  logic [DATA_W-1:0]        iw_write_data;
  logic                     iw_aux_valid;
  logic [ADDR_W-1:0]        iw_aux_addr;
  logic [DATA_W-1:0]        iw_aux_data;
  logic                     ow_aux_ready;
  logic                     ow_aux_pending;
  logic [4*DATA_W-1:0]      ow_taps;

  modport master (
    output iw_read_addr, iw_write_enable, iw_write_addr, iw_write_data,
           iw_aux_valid, iw_aux_addr, iw_aux_data,
    input  ow_read_data, ow_aux_ready, ow_aux_pending, ow_taps
  );

  modport slave (
    input  iw_read_addr, iw_write_enable, iw_write_addr, iw_write_data,
           iw_aux_valid, iw_aux_addr, iw_aux_data,
    output ow_read_data, ow_aux_ready, ow_aux_pending, ow_taps
  );

endinterface

// File: rtl/regcsr_auxfifo.sv
// regcsr_auxfifo: synchronous FIFO buffering aux CSR writes.
//   iw_clk, iw_rst        : clock, async active-high reset (discards contents)
//   push, push_addr/data  : enqueue request (ignored when full)
//   pop                   : dequeue request (ignored when empty)
//   head_addr, head_data  : oldest entry
//   count                 : current occupancy, 0..AUX_DEPTH
module regcsr_auxfifo #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 8,
  parameter int AUX_DEPTH = 4
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(AUX_DEPTH):0]   count
);

  localparam int PW = $clog2(AUX_DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem [AUX_DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign do_push = push && (count < (PW+1)'(AUX_DEPTH));
  assign do_pop  = pop && (count != '0);

  assign {head_addr, head_data} = mem[rd_ptr];

  // Storage has no reset: clearing the pointers is enough to discard it.
  always_ff @(posedge iw_clk) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regcsr_mp.sv
// regcsr_mp: parametrised CSR register file.
//   iw_clk, iw_rst : clock, async active-high reset (all CSRs and aux FIFO)
//   bus (slave)    : NUM_RD combinational read ports, CPU write port,
//                    buffered aux write channel (valid/ready/pending),
//                    and 4-word tap bus of CSR[TAP_BASE..TAP_BASE+3].
// CPU writes always commit; the aux FIFO head drains only on cycles without
// a CPU write. CSR[CYC_IDX] counts edges unless written that edge.
module regcsr_mp
  import csr_pkg::*;
#(
  parameter int         DATA_W    = DEF_DATA_W,
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         NUM_RD    = 2,
  parameter int         AUX_DEPTH = 4,
  parameter logic [7:0] CYC_IDX   = CSR_CYC,
  parameter logic [7:0] TAP_BASE  = CSR_MATH_CTRL
) (
  input  logic           iw_clk,
  input  logic           iw_rst,
  regcsr_mp_if.slave     bus
);

  localparam int                CW    = $clog2(AUX_DEPTH) + 1;
  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CYC_A = ADDR_W'(CYC_IDX);
  localparam logic [ADDR_W-1:0] TAP_A = ADDR_W'(TAP_BASE);

  logic [DATA_W-1:0] csr [DEPTH];

  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Status depends on registered count only, so no path from valid/enable.
  assign bus.ow_aux_ready   = count < CW'(AUX_DEPTH);
  assign bus.ow_aux_pending = count != '0;

  assign push = bus.iw_aux_valid && bus.ow_aux_ready;
  assign pop  = bus.ow_aux_pending && !bus.iw_write_enable;

  regcsr_auxfifo #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AUX_DEPTH (AUX_DEPTH)
  ) u_auxfifo (
    .iw_clk    (iw_clk),
    .iw_rst    (iw_rst),
    .push      (push),
    .push_addr (bus.iw_aux_addr),
    .push_data (bus.iw_aux_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count)
  );

  always_comb begin
    wr_en   = bus.iw_write_enable || pop;
    wr_addr = bus.iw_write_enable ? bus.iw_write_addr : head_addr;
    wr_data = bus.iw_write_enable ? bus.iw_write_data : head_data;
  end

  // The counter increment is scheduled first so a same-edge write to
  // CYC_IDX overrides it (last non-blocking assignment wins).
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) csr[i] <= '0;
    end else begin
      csr[CYC_A] <= csr[CYC_A] + DATA_W'(1);
      if (wr_en) csr[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    bus.ow_read_data = '0;
    for (int unsigned k = 0; k < NUM_RD; k++)
      bus.ow_read_data[k*DATA_W +: DATA_W] = csr[bus.iw_read_addr[k*ADDR_W +: ADDR_W]];
  end

  always_comb begin
    bus.ow_taps = '0;
    for (int unsigned j = 0; j < 4; j++)
      bus.ow_taps[j*DATA_W +: DATA_W] = csr[TAP_A + ADDR_W'(j)];
  end

endmodule

// File: tb/tb_regcsr_mp.sv
// tb_regcsr_mp: self-checking bench for regcsr_mp. A behavioural model
// (array + queue of pending aux writes) is advanced once per clock edge and
// compared against status, taps and read ports on the falling edge.
module tb_regcsr_mp;
  import csr_pkg::*;

  localparam int DW = 24;
  localparam int AW = 8;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b1;

  regcsr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) bus ();

  regcsr_mp #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .NUM_RD    (2),
    .AUX_DEPTH (4),
    .CYC_IDX   (8'h01),
    .TAP_BASE  (8'h10)
  ) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .bus    (bus)
  );

  always #5 iw_clk = ~iw_clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] mref [256];
  aux_entry_t    q [$];
  bit            acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return bus.ow_read_data[k*DW +: DW];
  endfunction

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.iw_read_addr[k*AW +: AW] = a;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mref[i] = '0;
    q.delete();
  endtask

  // One clock edge of the reference: accept decided on pre-edge fill level,
  // CPU write beats the queue head, counter bumps unless overwritten.
  task automatic model_edge();
    bit         rdy;
    aux_entry_t e;
    rdy = q.size() < 4;
    acc = bus.iw_aux_valid && rdy;
    mref[1] = mref[1] + 1;
    if (bus.iw_write_enable) begin
      mref[bus.iw_write_addr] = bus.iw_write_data;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      mref[e.addr] = e.data;
    end
    if (acc) begin
      e.addr = bus.iw_aux_addr;
      e.data = bus.iw_aux_data;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    check_eq("ready", bus.ow_aux_ready, q.size() < 4);
    check_eq("pending", bus.ow_aux_pending, q.size() != 0);
    for (int j = 0; j < 4; j++)
      check_eq("tap", bus.ow_taps[j*DW +: DW], mref[8'h10 + j]);
    for (int k = 0; k < 2; k++)
      check_eq("rdport", rd(k), mref[bus.iw_read_addr[k*AW +: AW]]);
  endtask

  task automatic cycle();
    @(posedge iw_clk);
    model_edge();
    @(negedge iw_clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.iw_write_enable = 1'b0;
    bus.iw_write_addr   = '0;
    bus.iw_write_data   = '0;
    bus.iw_aux_valid    = 1'b0;
    bus.iw_aux_addr     = '0;
    bus.iw_aux_data     = '0;
  endtask

  initial begin
    int k;
    bus.iw_read_addr = '0;
    idle_inputs();
    model_reset();

    // Reset state
    repeat (2) @(negedge iw_clk);
    for (int a = 0; a < 4; a++) begin
      set_rd(0, AW'(8'h10 + a));
      set_rd(1, AW'(8'h10 + a));
      #1;
      check_eq("rst_rd0", rd(0), 0);
      check_eq("rst_rd1", rd(1), 0);
    end
    check_eq("rst_ready", bus.ow_aux_ready, 1);
    check_eq("rst_pending", bus.ow_aux_pending, 0);
    check_eq("rst_taps", bus.ow_taps[31:0], 0);
    set_rd(0, 8'h01);
    iw_rst = 1'b0;
    cycle();
    check_eq("cyc_first", rd(0), 24'h000001);

    // CPU write latency
    set_rd(1, 8'h20);
    bus.iw_write_enable = 1'b1;
    bus.iw_write_addr   = 8'h20;
    bus.iw_write_data   = 24'h123456;
    #1;
    check_eq("wr_not_yet", rd(1), 24'h000000);
    cycle();
    check_eq("wr_visible", rd(1), 24'h123456);

    // Aux vs CPU collision on the same CSR
    bus.iw_write_data = 24'h555555;
    bus.iw_aux_valid  = 1'b1;
    bus.iw_aux_addr   = 8'h20;
    bus.iw_aux_data   = 24'hAAAAAA;
    for (int c = 0; c < 3; c++) begin
      cycle();
      bus.iw_aux_valid = 1'b0;
      check_eq("coll_cpu", rd(1), 24'h555555);
      check_eq("coll_pend", bus.ow_aux_pending, 1);
    end
    bus.iw_write_enable = 1'b0;
    cycle();
    check_eq("coll_aux", rd(1), 24'hAAAAAA);
    check_eq("coll_drain", bus.ow_aux_pending, 0);

    // Fill FIFO under a held CPU write, then drain in order
    bus.iw_write_enable = 1'b1;
    bus.iw_write_addr   = 8'h30;
    bus.iw_write_data   = 24'h0F0F0F;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.iw_aux_valid = 1'b1;
      bus.iw_aux_addr  = AW'(8'h40 + k);
      bus.iw_aux_data  = DW'(24'hA00000 + k);
      cycle();
      if (acc) k++;
    end
    check_eq("full_count", k, 4);
    check_eq("full_ready", bus.ow_aux_ready, 0);
    bus.iw_write_enable = 1'b0;
    cycle();
    check_eq("fifth_held", acc, 0);
    check_eq("ready_after_pop", bus.ow_aux_ready, 1);
    cycle();
    check_eq("fifth_taken", acc, 1);
    bus.iw_aux_valid = 1'b0;
    begin
      int budget = 10;
      while (bus.ow_aux_pending && budget > 0) begin
        cycle();
        budget--;
      end
      check_eq("drain_bound", bus.ow_aux_pending, 0);
    end
    for (int a = 0; a < 5; a++) begin
      set_rd(0, AW'(8'h40 + a));
      #1;
      check_eq("order", rd(0), 24'hA00000 + a);
    end

    // Counter load and wrap
    set_rd(0, 8'h01);
    bus.iw_write_enable = 1'b1;
    bus.iw_write_addr   = 8'h01;
    bus.iw_write_data   = 24'hFFFFFE;
    cycle();
    bus.iw_write_enable = 1'b0;
    check_eq("cyc_load", rd(0), 24'hFFFFFE);
    cycle();
    check_eq("cyc_max", rd(0), 24'hFFFFFF);
    cycle();
    check_eq("cyc_wrap", rd(0), 24'h000000);
    cycle();
    check_eq("cyc_after", rd(0), 24'h000001);

    // Reset with queued aux entries
    bus.iw_write_enable = 1'b1;
    bus.iw_write_addr   = 8'h50;
    bus.iw_write_data   = 24'h777777;
    for (int c = 0; c < 3; c++) begin
      bus.iw_aux_valid = 1'b1;
      bus.iw_aux_addr  = AW'(8'h60 + c);
      bus.iw_aux_data  = DW'(24'hB00000 + c + 1);
      cycle();
    end
    check_eq("pre_rst_pend", bus.ow_aux_pending, 1);
    idle_inputs();
    iw_rst = 1'b1;
    model_reset();
    set_rd(0, 8'h60);
    set_rd(1, 8'h50);
    #1;
    check_eq("arst_pend", bus.ow_aux_pending, 0);
    check_eq("arst_ready", bus.ow_aux_ready, 1);
    check_eq("arst_aux", rd(0), 0);
    check_eq("arst_cpu", rd(1), 0);
    @(negedge iw_clk);
    iw_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_rd(0, AW'(8'h60 + c));
      cycle();
      check_eq("no_commit", rd(0), 0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.iw_write_enable = ($urandom_range(0, 99) < 45);
      bus.iw_write_addr   = ($urandom_range(0, 7) == 0) ? 8'h01 : AW'($urandom_range(0, 31));
      bus.iw_write_data   = DW'($urandom);
      if (!bus.iw_aux_valid || acc) begin
        bus.iw_aux_valid = ($urandom_range(0, 99) < 60);
        bus.iw_aux_addr  = ($urandom_range(0, 7) == 0) ? 8'h01 : AW'($urandom_range(0, 31));
        bus.iw_aux_data  = DW'($urandom);
      end
      set_rd(0, AW'($urandom_range(0, 31)));
      set_rd(1, ($urandom_range(0, 3) == 0) ? 8'h01 : AW'($urandom_range(0, 31)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
